// File: rtl/ddr3_axi_arb.sv
// Round-robin arbiter sharing one DDR3 IP AXI port between two masters.
// Write (AW+W) and read (AR+R) channels are arbitrated independently.
module ddr3_axi_arb #(
  parameter int CTRL_ADDR_WIDTH = 28,
  parameter int MEM_DQ_WIDTH    = 32
) (
  input  logic                         core_clk,
  input  logic                         core_clk_rst_n,
  input  logic                         ddrc_init_done,
  input  logic [CTRL_ADDR_WIDTH-1:0]   m0_awaddr,
  input  logic [3:0]                   m0_awlen,
  input  logic                         m0_awvalid,
  output logic                         m0_awready,
  input  logic [MEM_DQ_WIDTH*8-1:0]    m0_wdata,
  output logic                         m0_wready,
  output logic                         m0_wlast,
  input  logic [CTRL_ADDR_WIDTH-1:0]   m0_araddr,
  input  logic [3:0]                   m0_arlen,
  input  logic                         m0_arvalid,
  output logic                         m0_arready,
  output logic                         m0_rvalid,
  output logic                         m0_rlast,
  input  logic [CTRL_ADDR_WIDTH-1:0]   m1_awaddr,
  input  logic [3:0]                   m1_awlen,
  input  logic                         m1_awvalid,
  output logic                         m1_awready,
  input  logic [MEM_DQ_WIDTH*8-1:0]    m1_wdata,
  output logic                         m1_wready,
  output logic                         m1_wlast,
  input  logic [CTRL_ADDR_WIDTH-1:0]   m1_araddr,
  input  logic [3:0]                   m1_arlen,
  input  logic                         m1_arvalid,
  output logic                         m1_arready,
  output logic                         m1_rvalid,
  output logic                         m1_rlast,
  output logic [MEM_DQ_WIDTH*8-1:0]    rdata,
  output logic [CTRL_ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [3:0]                   axi_awlen,
  output logic                         axi_awvalid,
  input  logic                         axi_awready,
  output logic [MEM_DQ_WIDTH*8-1:0]    axi_wdata,
  input  logic                         axi_wready,
  input  logic                         axi_wusero_last,
  output logic [CTRL_ADDR_WIDTH-1:0]   axi_araddr,
  output logic [3:0]                   axi_arlen,
  output logic                         axi_arvalid,
  input  logic                         axi_arready,
  input  logic [MEM_DQ_WIDTH*8-1:0]    axi_rdata,
  input  logic                         axi_rvalid,
  input  logic                         axi_rlast,
  output logic [1:0]                   wr_gnt,
  output logic [1:0]                   rd_gnt
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA} w_st_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_st_t;

  w_st_t w_st, w_nxt;
  r_st_t r_st, r_nxt;
  logic [1:0] wg_nxt, rg_nxt;
  logic w_last, w_last_nxt;
  logic r_last, r_last_nxt;
  logic aw_req, ar_req;
  logic w_a, w_d, r_a, r_d;

  // last == 1 means M1 was served last, so M0 wins a tie
  function automatic logic [1:0] pick(
    input logic [1:0] req,
    input logic       last
  );
    if (req == 2'b11) return last ? 2'b01 : 2'b10;
    return req;
  endfunction

  always_ff @(posedge core_clk or negedge core_clk_rst_n) begin
    if (!core_clk_rst_n) begin
      w_st   <= W_IDLE;
      r_st   <= R_IDLE;
      wr_gnt <= 2'b00;
      rd_gnt <= 2'b00;
      w_last <= 1'b1;
      r_last <= 1'b1;
    end else begin
      w_st   <= w_nxt;
      r_st   <= r_nxt;
      wr_gnt <= wg_nxt;
      rd_gnt <= rg_nxt;
      w_last <= w_last_nxt;
      r_last <= r_last_nxt;
    end
  end

  assign aw_req = wr_gnt[1] ? m1_awvalid : m0_awvalid;
  assign ar_req = rd_gnt[1] ? m1_arvalid : m0_arvalid;

  always_comb begin
    w_nxt      = w_st;
    wg_nxt     = wr_gnt;
    w_last_nxt = w_last;
    unique case (w_st)
      W_IDLE: begin
        if (ddrc_init_done && (m0_awvalid || m1_awvalid)) begin
          wg_nxt = pick({m1_awvalid, m0_awvalid}, w_last);
          w_nxt  = W_ADDR;
        end
      end
      W_ADDR: begin
        if (!aw_req) begin
          w_nxt  = W_IDLE;
          wg_nxt = 2'b00;
        end else if (axi_awready) begin
          w_nxt = W_DATA;
        end
      end
      W_DATA: begin
        if (axi_wready && axi_wusero_last) begin
          w_nxt      = W_IDLE;
          wg_nxt     = 2'b00;
          w_last_nxt = wr_gnt[1];
        end
      end
      default: begin
        w_nxt  = W_IDLE;
        wg_nxt = 2'b00;
      end
    endcase
  end

  always_comb begin
    r_nxt      = r_st;
    rg_nxt     = rd_gnt;
    r_last_nxt = r_last;
    unique case (r_st)
      R_IDLE: begin
        if (ddrc_init_done && (m0_arvalid || m1_arvalid)) begin
          rg_nxt = pick({m1_arvalid, m0_arvalid}, r_last);
          r_nxt  = R_ADDR;
        end
      end
      R_ADDR: begin
        if (!ar_req) begin
          r_nxt  = R_IDLE;
          rg_nxt = 2'b00;
        end else if (axi_arready) begin
          r_nxt = R_DATA;
        end
      end
      R_DATA: begin
        if (axi_rvalid && axi_rlast) begin
          r_nxt      = R_IDLE;
          rg_nxt     = 2'b00;
          r_last_nxt = rd_gnt[1];
        end
      end
      default: begin
        r_nxt  = R_IDLE;
        rg_nxt = 2'b00;
      end
    endcase
  end

  assign w_a = (w_st == W_ADDR);
  assign w_d = (w_st == W_DATA);
  assign r_a = (r_st == R_ADDR);
  assign r_d = (r_st == R_DATA);

  // address/data muxes follow the grant register with no extra stage
  assign axi_awvalid = w_a & aw_req;
  assign axi_awaddr  = wr_gnt[1] ? m1_awaddr :
                       wr_gnt[0] ? m0_awaddr : '0;
  assign axi_awlen   = wr_gnt[1] ? m1_awlen :
                       wr_gnt[0] ? m0_awlen : '0;
  assign axi_wdata   = wr_gnt[1] ? m1_wdata :
                       wr_gnt[0] ? m0_wdata : '0;

  assign m0_awready = w_a & wr_gnt[0] & axi_awready;
  assign m1_awready = w_a & wr_gnt[1] & axi_awready;
  assign m0_wready  = w_d & wr_gnt[0] & axi_wready;
  assign m1_wready  = w_d & wr_gnt[1] & axi_wready;
  assign m0_wlast   = w_d & wr_gnt[0] & axi_wusero_last;
  assign m1_wlast   = w_d & wr_gnt[1] & axi_wusero_last;

  assign axi_arvalid = r_a & ar_req;
  assign axi_araddr  = rd_gnt[1] ? m1_araddr :
                       rd_gnt[0] ? m0_araddr : '0;
  assign axi_arlen   = rd_gnt[1] ? m1_arlen :
                       rd_gnt[0] ? m0_arlen : '0;

  assign m0_arready = r_a & rd_gnt[0] & axi_arready;
  assign m1_arready = r_a & rd_gnt[1] & axi_arready;
  assign m0_rvalid  = r_d & rd_gnt[0] & axi_rvalid;
  assign m1_rvalid  = r_d & rd_gnt[1] & axi_rvalid;
  assign m0_rlast   = r_d & rd_gnt[0] & axi_rlast;
  assign m1_rlast   = r_d & rd_gnt[1] & axi_rlast;

  assign rdata = axi_rdata;

endmodule

// File: doc/ddr3_axi_arb.md
Name: ddr3_axi_arb

Overview:
- Two-requester arbiter that shares the single DDR3 IP AXI port between masters M0 and M1 in the core_clk domain.
- Write channel (AW+W) and read channel (AR+R) are arbitrated independently, each with round-robin priority.
- A grant is held for a whole burst. Write: from address handshake to the last data beat. Read: from address handshake to rlast.
- Sits between requesters such as ddr3_ctrl instances and ddr3_ip; uses the IP's AXI flavour: no wvalid (wready pulls data), no rready.

Parameters:
- CTRL_ADDR_WIDTH, 28, AXI address width.
- MEM_DQ_WIDTH, 32, DDR DQ width; AXI data width is MEM_DQ_WIDTH*8.

Ports:
- core_clk  in  1  clock
- core_clk_rst_n  in  1  reset, asynchronous, active-low
- ddrc_init_done  in  1  DDR calibration complete; no grant is issued while low
- mN_awaddr  in  CTRL_ADDR_WIDTH  master N write address (N=0,1; all mN ports exist for both masters)
- mN_awlen  in  4  master N write burst length-1
- mN_awvalid  in  1  master N write request
- mN_awready  out  1  master N write address accepted
- mN_wdata  in  MEM_DQ_WIDTH*8  master N write data
- mN_wready  out  1  master N data beat taken
- mN_wlast  out  1  master N last write beat
- mN_araddr  in  CTRL_ADDR_WIDTH  master N read address
- mN_arlen  in  4  master N read burst length-1
- mN_arvalid  in  1  master N read request
- mN_arready  out  1  master N read address accepted
- mN_rvalid  out  1  master N read beat valid
- mN_rlast  out  1  master N last read beat
- rdata  out  MEM_DQ_WIDTH*8  read data, shared by both masters
- axi_awaddr  out  CTRL_ADDR_WIDTH  to IP
- axi_awlen  out  4  to IP
- axi_awvalid  out  1  to IP
- axi_awready  in  1  from IP
- axi_wdata  out  MEM_DQ_WIDTH*8  to IP
- axi_wready  in  1  from IP
- axi_wusero_last  in  1  from IP
- axi_araddr  out  CTRL_ADDR_WIDTH  to IP
- axi_arlen  out  4  to IP
- axi_arvalid  out  1  to IP
- axi_arready  in  1  from IP
- axi_rdata  in  MEM_DQ_WIDTH*8  from IP
- axi_rvalid  in  1  from IP
- axi_rlast  in  1  from IP
- wr_gnt  out  2  one-hot write grant (debug)
- rd_gnt  out  2  one-hot read grant (debug)

Behaviour:
- Reset:
  - Both FSMs go to IDLE.
  - wr_gnt = rd_gnt = 2'b00.
  - Round-robin pointers favour M0.
  - Every valid, ready and last output is 0.
  - axi_awaddr, axi_awlen, axi_araddr, axi_arlen are 0.
- Write FSM, states W_IDLE, W_ADDR, W_DATA:
  - W_IDLE: if ddrc_init_done and any mN_awvalid, register a grant. If both request, the non-last-served master wins; otherwise the sole requester wins. Go to W_ADDR. The grant is visible the next cycle, giving 1-cycle arbitration latency.
  - W_ADDR:
    - axi_awaddr, axi_awlen and axi_awvalid are muxed combinationally from the granted master; axi_awready is routed only to that master's mN_awready.
    - On axi_awvalid & axi_awready, go to W_DATA.
    - If the granted mN_awvalid drops before the handshake, return to W_IDLE, clear the grant and leave the pointer unchanged.
  - W_DATA:
    - axi_wdata is muxed from the granted master; axi_wready goes to its mN_wready and axi_wusero_last to its mN_wlast.
    - On axi_wready & axi_wusero_last, go to W_IDLE, clear the grant and set the pointer to "last served = granted".
  - Non-granted masters always see ready/last = 0.
- Read FSM, states R_IDLE, R_ADDR, R_DATA:
  - Identical arbitration rules to the write FSM, on mN_arvalid.
  - R_DATA: axi_rvalid/axi_rlast are routed to the granted master's mN_rvalid/mN_rlast.
  - rdata = axi_rdata, unmuxed, at all times.
  - On axi_rvalid & axi_rlast, go to R_IDLE and update the pointer.
- One outstanding burst per channel.
- Read and write FSMs are fully independent: M0 may write while M1 reads.
- A new request in W_DATA or R_DATA waits; it is never preempted.
- ddrc_init_done falling mid-burst does not abort the burst; it blocks only new grants.
- An IP ready pulse outside ADDR/DATA states is ignored; no state change occurs.
- Asynchronous reset mid-burst forces IDLE immediately; the in-flight burst is abandoned.
- Grant to data path: 0 cycles after the state register updates; no extra pipeline.

Test Plan:
- Reset, ddrc_init_done=0, m0_awvalid=1 for 20 cycles -> wr_gnt=00 and axi_awvalid=0 throughout. Raise init_done -> wr_gnt=01 the next cycle.
- M0 and M1 both assert awvalid (awlen=3) at once -> M0 is served first: 4 wready beats, m0_wlast on beat 4, m1_wready stays 0. M1 is granted 1 cycle after W_IDLE; the third contest goes to M0.
- M0 reads addr 0x100 (arlen=7) while M1 writes addr 0x200 -> axi_arvalid and axi_awvalid are concurrent; m0_rvalid counts 8 with rlast on beat 8; m1_rvalid=0.
- M1 asserts awvalid then drops it before axi_awready -> FSM returns to W_IDLE, pointer unchanged, and M1 still has priority over M0 on the next contest.
- Assert reset during W_DATA beat 2 of 4 -> all outputs 0 within the same cycle; after release, a fresh M1 request is granted.
- Back-to-back M0-only read bursts -> M0 is granted each time; no starvation stall; 1 idle cycle between bursts.
